als_spi_reader: RTL and testbench
=================================

Name: als_spi_reader

Overview:
- SPI read master for the Pmod ALS light sensor (ADC081S021, 8-bit ADC, read-only SPI).
- Sits directly downstream of the clock divider. It consumes the divider's slow clk_div square wave as a bit-rate strobe, all in the single clk domain.
- Generates CS/SCLK, shifts in one 16-clock frame, and presents the 8-bit light reading with a one-cycle valid pulse.

Parameters:
AUTO, 1, 1 = free-running back-to-back conversions; 0 = a conversion starts only on a start pulse.
GAP_TICKS, 2, number of clk_div rising edges cs_n is held high between frames (quiet time); legal range 1..15.

Ports:
clk  input  1  system clock (100 MHz); everything is synchronous to it.
rst  input  1  asynchronous, active-high reset.
clk_div  input  1  slow square wave from the clock divider, registered in the clk domain; used only as a strobe, never as a clock.
start  input  1  one-cycle request for a conversion; ignored when AUTO=1.
miso  input  1  serial data from the sensor.
cs_n  output  1  chip select, active low.
sclk  output  1  SPI clock to the sensor; idles high.
data  output  8  last valid light reading, held until the next frame completes.
data_valid  output  1  one-cycle pulse when data updates.
frame_err  output  1  leading-zero check result; valid with data_valid, held until the next data_valid.
busy  output  1  high from an accepted start until the end of the gap period.

Behaviour:
- Reset (async, active-high):
  - cs_n=1, sclk=1, data=0, data_valid=0, frame_err=0, busy=0.
  - State=IDLE, counters=0, shift register=0, pending-start flag=0.
  - Reset mid-frame aborts the frame immediately; cs_n rises asynchronously.
- Edge strobes:
  - dq is a registered copy of clk_div.
  - rise = clk_div & ~dq; fall = ~clk_div & dq.
  - Each strobe is exactly one clk cycle wide.
  - Outputs react to a strobe on the following clk edge, so latency is 1 clk from a clk_div transition.
- States: IDLE, ARM, SHIFT, GAP.
- IDLE:
  - cs_n=1, sclk=1, busy=0.
  - A start pulse (AUTO=0), or every cycle when AUTO=1, sets the pending flag and moves to ARM; busy=1 from the next clk.
- ARM: on the next rise, cs_n<=0, bit_cnt<=0, go to SHIFT. sclk stays high, giving a half clk_div period of CS setup.
- SHIFT:
  - On fall: sclk<=0.
  - On rise: sclk<=1, shreg <= {shreg[14:0], miso}, bit_cnt++.
  - miso is sampled from the same clk cycle as the rise strobe; the sensor drives bits on SCLK falling edges.
  - On the 16th rise, take the 16th sample, then:
    - cs_n<=1 and sclk held 1.
    - data<=final shreg[12:5], i.e. samples 4..11, D7 first.
    - frame_err <= (final shreg[15:13] != 0).
    - data_valid<=1 for one cycle.
    - gap_cnt<=0, go to GAP.
  - Exactly 16 sclk falling edges and 16 rising edges per frame.
- GAP:
  - cs_n=1; count rise strobes.
  - When gap_cnt reaches GAP_TICKS, go to IDLE.
  - With AUTO=1, IDLE immediately re-arms, so the frame period is 16 + GAP_TICKS + 1 clk_div periods.
- start arriving while busy=1 is dropped and not queued. start in the same cycle as a rise strobe while IDLE is accepted; ARM then waits for the next rise.
- bit_cnt is 5 bits, with no wrap within a frame. data never changes except on a data_valid cycle.
- If clk_div stops, the block stalls in its current state with outputs held; no timeout.

Test Plan:
- Bench clk_div has a 16-clk period. The sensor model drives 3'b000, 8'hA5, then 5'b00000 on successive sclk falls. With AUTO=0 and one start pulse: cs_n low for 16 sclk periods, 16 sclk falls counted, data=8'hA5, data_valid high exactly 1 cycle, frame_err=0, busy returns to 0 after the GAP_TICKS=2 rising edges.
- Sensor model drives leading bits 3'b010 with data 8'h3C -> data=8'h3C, frame_err=1 on the data_valid cycle.
- A second start pulse is issued at sclk fall #5 of the first frame -> it is ignored; only one data_valid occurs and no second cs_n low period follows.
- rst asserted at sclk fall #9 -> cs_n=1 and sclk=1 within the same cycle (async). data stays 0 and there is no data_valid. After release with AUTO=0, the block idles until start.
- AUTO=1 with the model alternating 8'h01 then 8'hFE -> data_valid pulses exactly 19 clk_div periods apart. data sequence is 01, FE, 01, and cs_n is high for at least 2 clk_div rising edges between frames.
- clk_div is held constant for 200 clk mid-frame -> no sclk toggles and no state change; on resume the frame completes with the correct data.

Source files
------------

// File: rtl/als_spi_reader.sv
// SPI read master for the Pmod ALS (ADC081S021): one 16-clock read frame per conversion,
// paced by rise/fall strobes taken from the clock divider's clk_div square wave.
module als_spi_reader #(
    parameter int unsigned AUTO      = 1,
    parameter int unsigned GAP_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_div,
    input  logic       start,
    input  logic       miso,
    output logic       cs_n,
    output logic       sclk,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int unsigned FRAME_BITS = 16;
    localparam logic [4:0]  LAST_BIT   = 5'(FRAME_BITS);
    localparam logic [3:0]  GAP_LAST   = 4'(GAP_TICKS);

    typedef enum logic [1:0] {IDLE, ARM, SHIFT, GAP} state_e;

    state_e      state_q, state_d;
    logic        dq_q;
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic [7:0]  data_q, data_d;
    logic        dv_q, dv_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        pend_q, pend_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [15:0] shreg_q, shreg_d;

    logic        rise_c, fall_c;
    logic [15:0] shreg_next_c;
    logic [4:0]  bit_inc_c;
    logic [3:0]  gap_inc_c;

    // One-clk strobes on each clk_div transition
    assign rise_c       = clk_div & ~dq_q;
    assign fall_c       = ~clk_div & dq_q;
    assign shreg_next_c = {shreg_q[14:0], miso};
    assign bit_inc_c    = bit_cnt_q + 5'd1;
    assign gap_inc_c    = gap_cnt_q + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            dq_q      <= 1'b0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b1;
            data_q    <= 8'd0;
            dv_q      <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            pend_q    <= 1'b0;
            bit_cnt_q <= 5'd0;
            gap_cnt_q <= 4'd0;
            shreg_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            dq_q      <= clk_div;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            data_q    <= data_d;
            dv_q      <= dv_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            pend_q    <= pend_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            shreg_q   <= shreg_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        data_d    = data_q;
        dv_d      = 1'b0;
        err_d     = err_q;
        busy_d    = busy_q;
        pend_d    = pend_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        shreg_d   = shreg_q;

        case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b1;
                busy_d = 1'b0;
                if ((AUTO != 0) || start) begin
                    pend_d  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ARM;
                end
            end
            // CS drops on a rise; SCLK stays high for half a period of setup
            ARM: begin
                if (rise_c && pend_q) begin
                    cs_n_d    = 1'b0;
                    bit_cnt_d = 5'd0;
                    pend_d    = 1'b0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (fall_c) begin
                    sclk_d = 1'b0;
                end else if (rise_c) begin
                    sclk_d    = 1'b1;
                    shreg_d   = shreg_next_c;
                    bit_cnt_d = bit_inc_c;
                    if (bit_inc_c == LAST_BIT) begin
                        cs_n_d    = 1'b1;
                        data_d    = shreg_next_c[12:5];
                        err_d     = |shreg_next_c[15:13];
                        dv_d      = 1'b1;
                        gap_cnt_d = 4'd0;
                        state_d   = GAP;
                    end
                end
            end
            GAP: begin
                cs_n_d = 1'b1;
                if (rise_c) begin
                    gap_cnt_d = gap_inc_c;
                    if (gap_inc_c == GAP_LAST) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cs_n       = cs_n_q;
    assign sclk       = sclk_q;
    assign data       = data_q;
    assign data_valid = dv_q;
    assign frame_err  = err_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_als_spi_reader.sv
// Bench for als_spi_reader: sensor models, a table of fixed frames, random frames
// against a sample-list reference, reset/stall/dropped-start sequences and a free-running instance.
module tb_als_spi_reader;
    localparam int GAP     = 2;
    localparam int DIV_P   = 16;
    localparam int FRAME_C = 16 * DIV_P;

    logic       clk = 1'b0;
    logic       clk_div = 1'b0;
    logic [3:0] div_cnt = 4'd0;
    bit         div_run = 1'b1;
    int         rise_cnt = 0;

    logic       rst, start, miso;
    logic       cs_n, sclk, data_valid, frame_err, busy;
    logic [7:0] data;

    logic       a_rst, a_start, a_miso;
    logic       a_cs_n, a_sclk, a_dv, a_err, a_busy;
    logic [7:0] a_data;

    als_spi_reader #(.AUTO(0), .GAP_TICKS(GAP)) u_dut (
        .clk(clk), .rst(rst), .clk_div(clk_div), .start(start), .miso(miso),
        .cs_n(cs_n), .sclk(sclk), .data(data), .data_valid(data_valid),
        .frame_err(frame_err), .busy(busy)
    );

    als_spi_reader #(.AUTO(1), .GAP_TICKS(GAP)) u_auto (
        .clk(clk), .rst(a_rst), .clk_div(clk_div), .start(a_start), .miso(a_miso),
        .cs_n(a_cs_n), .sclk(a_sclk), .data(a_data), .data_valid(a_dv),
        .frame_err(a_err), .busy(a_busy)
    );

    always #5 clk = ~clk;

    // Divider model: 16-clk square wave, pausable to emulate a stalled divider
    always @(negedge clk) begin
        if (div_run) begin
            div_cnt = div_cnt + 4'd1;
            if (div_cnt == 4'd8) rise_cnt++;
            clk_div = div_cnt[3];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor and sensor models, sampled 1 time unit after each active edge
    int          cyc = 0, cs_falls = 0, fall_cnt = 0, cs_low = 0, sclk_toggles = 0;
    int          dv_pulses = 0, dv_long = 0, dv_cyc = 0, busy_fall_cyc = 0, data_glitch = 0;
    logic        cs_prev = 1'b1, sclk_prev = 1'b1, dv_prev = 1'b0, busy_prev = 1'b0, rst_prev = 1'b1;
    logic [7:0]  data_prev = 8'd0;
    logic [15:0] cur_word = 16'd0;

    int          a_frames = 0, a_fidx = 0, a_rise_at_dv = 0;
    bit          a_after_dv = 1'b0;
    logic        a_cs_prev = 1'b1, a_sclk_prev = 1'b1;
    logic [15:0] a_word = 16'd0;
    int          a_dv_cyc[$];
    logic [7:0]  a_dv_data[$];
    int          a_gap[$];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (cs_prev && !cs_n) begin cs_falls++; fall_cnt = 0; cs_low = 0; end
        if (!cs_n) cs_low++;
        if (sclk_prev && !sclk && !cs_n) begin
            fall_cnt++;
            if (fall_cnt <= 16) miso = cur_word[4'(16 - fall_cnt)];
        end
        if (sclk != sclk_prev) sclk_toggles++;
        if (data_valid) begin dv_pulses++; dv_cyc = cyc; end
        if (data_valid && dv_prev) dv_long++;
        if (busy_prev && !busy) busy_fall_cyc = cyc;
        if (!rst && !rst_prev && !data_valid && data != data_prev) data_glitch++;
        cs_prev = cs_n; sclk_prev = sclk; dv_prev = data_valid;
        busy_prev = busy; rst_prev = rst; data_prev = data;

        if (a_cs_prev && !a_cs_n) begin
            a_frames++;
            a_fidx = 0;
            a_word = (a_frames % 2 == 1) ? {3'b000, 8'h01, 5'b00000} : {3'b000, 8'hFE, 5'b00000};
            if (a_after_dv) begin a_gap.push_back(rise_cnt - a_rise_at_dv); a_after_dv = 1'b0; end
        end
        if (a_sclk_prev && !a_sclk && !a_cs_n) begin
            a_fidx++;
            if (a_fidx <= 16) a_miso = a_word[4'(16 - a_fidx)];
        end
        if (a_dv) begin
            a_dv_cyc.push_back(cyc);
            a_dv_data.push_back(a_data);
            a_rise_at_dv = rise_cnt;
            a_after_dv = 1'b1;
        end
        a_cs_prev = a_cs_n; a_sclk_prev = a_sclk;
    end

    // Reference: frame is a list of 16 samples; reading = samples 4..11, error = any of 1..3 set
    function automatic void ref_model(input logic [15:0] word, output logic [7:0] d, output logic e);
        logic samples [16];
        for (int k = 0; k < 16; k++) samples[k] = word[4'(15 - k)];
        d = 8'd0;
        for (int k = 3; k < 11; k++) d = {d[6:0], samples[k]};
        e = samples[0] | samples[1] | samples[2];
    endfunction

    task automatic run_frame(input logic [15:0] word, input logic [7:0] ed, input logic ee,
                             input bit second_start, input bit stall, input string tag);
        int  f0, p0, l0, t0, n;
        bit  issued, stalled, done;
        cur_word = word;
        f0 = cs_falls; p0 = dv_pulses; l0 = dv_long;
        issued = 1'b0; stalled = 1'b0; done = 1'b0; n = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({tag, ".busy_on_start"}, 32'(busy), 32'd1);
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
            if (start) start = 1'b0;
            else if (second_start && !issued && fall_cnt == 5) begin start = 1'b1; issued = 1'b1; end
            if (stall && !stalled && fall_cnt == 6) begin
                stalled = 1'b1;
                div_run = 1'b0;
                t0 = sclk_toggles;
                repeat (200) @(negedge clk);
                check({tag, ".stall_sclk"}, 32'(sclk_toggles), 32'(t0));
                check({tag, ".stall_cs"}, 32'(cs_n), 32'd0);
                check({tag, ".stall_falls"}, 32'(fall_cnt), 32'd6);
                check({tag, ".stall_dv"}, 32'(dv_pulses), 32'(p0));
                div_run = 1'b1;
            end
            done = (dv_pulses != p0);
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s.timeout: got no data_valid expected one within 3000 clk", tag);
            return;
        end
        check({tag, ".data"}, 32'(data), 32'(ed));
        check({tag, ".frame_err"}, 32'(frame_err), 32'(ee));
        check({tag, ".sclk_falls"}, 32'(fall_cnt), 32'd16);
        check({tag, ".cs_low_clk"}, 32'(cs_low), 32'(FRAME_C + (stall ? 200 : 0)));
        n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
        check({tag, ".busy_idle"}, 32'(busy), 32'd0);
        check({tag, ".gap_clk"}, 32'(busy_fall_cyc - dv_cyc), 32'(GAP * DIV_P));
        if (second_start) begin
            repeat (40 * DIV_P) @(negedge clk);
            check({tag, ".cs_frames"}, 32'(cs_falls - f0), 32'd1);
        end
        check({tag, ".dv_count"}, 32'(dv_pulses - p0), 32'd1);
        check({tag, ".dv_width"}, 32'(dv_long), 32'(l0));
    endtask

    typedef struct {
        logic [15:0] word;
        logic [7:0]  exp_data;
        logic        exp_err;
    } vec_t;

    initial begin
        vec_t        vecs [6];
        logic [15:0] w;
        logic [7:0]  ed;
        logic        ee;
        int          n;

        vecs[0] = '{{3'b000, 8'hA5, 5'b00000}, 8'hA5, 1'b0};
        vecs[1] = '{{3'b010, 8'h3C, 5'b00000}, 8'h3C, 1'b1};
        vecs[2] = '{{3'b100, 8'hFF, 5'b11111}, 8'hFF, 1'b1};
        vecs[3] = '{{3'b000, 8'h00, 5'b11111}, 8'h00, 1'b0};
        vecs[4] = '{{3'b001, 8'h81, 5'b01010}, 8'h81, 1'b1};
        vecs[5] = '{{3'b000, 8'h5A, 5'b10101}, 8'h5A, 1'b0};

        rst = 1'b1; a_rst = 1'b1; start = 1'b0; a_start = 1'b0; miso = 1'b0; a_miso = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_outputs", 32'({cs_n, sclk, data, data_valid, frame_err, busy}), 32'({2'b11, 8'h00, 3'b000}));
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Reset in the middle of a frame
        cur_word = vecs[0].word;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (fall_cnt != 9 && n < 2000) begin @(negedge clk); n++; end
        check("rst_reached_fall9", 32'(fall_cnt), 32'd9);
        rst = 1'b1;
        #1;
        check("rst_async_cs_sclk", 32'({cs_n, sclk}), 32'd3);
        check("rst_data", 32'(data), 32'd0);
        check("rst_no_dv", 32'(dv_pulses), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40 * DIV_P) @(negedge clk);
        check("idle_after_rst_cs", 32'(cs_falls), 32'd1);
        check("idle_after_rst_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 6; i++)
            run_frame(vecs[i].word, vecs[i].exp_data, vecs[i].exp_err, i == 0, 1'b0, $sformatf("vec%0d", i));

        for (int i = 0; i < 6; i++) begin
            w = 16'($urandom);
            ref_model(w, ed, ee);
            run_frame(w, ed, ee, 1'b0, 1'b0, $sformatf("rand%0d", i));
        end

        w = 16'($urandom);
        ref_model(w, ed, ee);
        run_frame(w, ed, ee, 1'b0, 1'b1, "stall");

        // Free-running instance
        @(negedge clk) a_rst = 1'b0;
        n = 0;
        while (a_dv_cyc.size() < 3 && n < 4000) begin @(negedge clk); n++; end
        if (a_dv_cyc.size() < 3) begin
            checks++; errors++;
            $display("FAIL auto.timeout: got %0d data_valid pulses expected 3", a_dv_cyc.size());
        end else begin
            for (int i = 0; i < 3; i++)
                check($sformatf("auto.data%0d", i), 32'(a_dv_data[i]), (i % 2 == 0) ? 32'h01 : 32'hFE);
            for (int i = 1; i < 3; i++)
                check($sformatf("auto.period%0d", i), 32'(a_dv_cyc[i] - a_dv_cyc[i-1]), 32'((16 + GAP + 1) * DIV_P));
            check("auto.gap_seen", 32'(a_gap.size() >= 1), 32'd1);
            if (a_gap.size() >= 1) check("auto.gap_rises_ge2", 32'(a_gap[0] >= GAP), 32'd1);
        end

        check("data_only_on_valid", 32'(data_glitch), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
